clock_mode_ctrl: RTL and testbench

//  Front-end sequencer for clock_top. Takes raw physical buttons (pButton), synchronizes and debounces

---
 rtl/clock_mode_ctrl.sv | 162 ++++++++++++++++
 tb/tb_clock_mode_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_mode_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : clock_mode_ctrl                                               |
// | Description: Button front-end and mode sequencer for clock_top.            |
// |              Synchronizes and debounces the raw buttons, turns rising      |
// |              edges into 1-mclk pulses, steps the edit mode on the mode     |
// |              button, drops back to the default mode after an idle          |
// |              timeout, and produces a 1 Hz blink enable for edit modes.     |
// | Ports      : mclk     in   main clock                                      |
// |              rst      in   asynchronous reset, active low                  |
// |              pButton  in   raw buttons [0] b1 [1] b2 [2] b3 [3] ampm [4] mode|
// |              clk_mode out  current mode (0 run, 1 time, 2 alarm, 3 date)   |
// |              vButton  out  1-mclk button pulses                            |
// |              mode_chg out  1-mclk pulse when clk_mode takes a new value    |
// |              blink    out  1 Hz square wave in modes 1-3, 0 in mode 0      |
// | Revision   : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
module clock_mode_ctrl #(
  parameter int M_FREQ    = 20_000_000,
  parameter int DEB_CYC   = 200_000,
  parameter int TIMEOUT_S = 30
) (
  input  logic       mclk,
  input  logic       rst,
  input  logic [4:0] pButton,
  output logic [1:0] clk_mode,
  output logic [3:0] vButton,
  output logic       mode_chg,
  output logic       blink
);

  localparam int CW = $clog2(DEB_CYC + 1);
  localparam int PW = (M_FREQ > 1) ? $clog2(M_FREQ) : 1;
  localparam int IW = $clog2(TIMEOUT_S + 1);

  localparam logic [CW-1:0] DEB_MAX  = CW'(DEB_CYC);
  localparam logic [PW-1:0] PRE_MAX  = PW'(M_FREQ - 1);
  localparam logic [PW-1:0] PRE_HALF = PW'(M_FREQ / 2);
  localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT_S);

  typedef enum logic [1:0] {
    M0 = 2'd0,
    M1 = 2'd1,
    M2 = 2'd2,
    M3 = 2'd3
  } mode_e;

  logic [4:0]    sync1_q, sync1_d;
  logic [4:0]    sync2_q, sync2_d;
  logic [4:0]    deb_q, deb_d;
  logic [CW-1:0] cnt_q [5];
  logic [CW-1:0] cnt_d [5];
  logic [PW-1:0] pre_q, pre_d;
  logic [IW-1:0] idle_q, idle_d;
  mode_e         mode_q, mode_d;
  logic [3:0]    vbutton_q, vbutton_d;
  logic          mode_chg_q, mode_chg_d;
  logic          blink_q, blink_d;

  logic [4:0]    p;
  logic          sec_tick;
  logic          timeout;

  always_comb begin
    sync1_d = pButton;
    sync2_d = sync1_q;

    // Per-bit debounce: count cycles of disagreement, accept the new level
    // only once the count has reached DEB_CYC; any agreement restarts it.
    deb_d = deb_q;
    for (int i = 0; i < 5; i++) begin
      if (sync2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DEB_MAX) begin
        deb_d[i] = sync2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end

    // Rising edge of the debounced level; every consumer registers it in the
    // same edge that updates deb_q, so each pulse is exactly one mclk wide.
    p = deb_d & ~deb_q;

    sec_tick = (pre_q == PRE_MAX);
    pre_d    = sec_tick ? '0 : pre_q + 1'b1;

    timeout = (mode_q != M0) && (idle_q == IDLE_MAX);

    // Mode press has priority over the idle timeout.
    mode_d = mode_q;
    if (p[4]) begin
      case (mode_q)
        M0:      mode_d = M1;
        M1:      mode_d = M2;
        M2:      mode_d = M3;
        default: mode_d = M0;
      endcase
    end else if (timeout) begin
      mode_d = M0;
    end
    mode_chg_d = (mode_d != mode_q);

    // A mode press masks every field press in the same cycle; field buttons
    // are dead in mode 0 while AM/PM stays live everywhere.
    if (p[4]) begin
      vbutton_d = 4'b0000;
    end else begin
      vbutton_d = {p[3], (mode_q != M0) ? p[2:0] : 3'b000};
    end

    if (mode_chg_d || (|p[3:0]) || (mode_q == M0)) begin
      idle_d = '0;
    end else if (sec_tick && (idle_q != IDLE_MAX)) begin
      idle_d = idle_q + 1'b1;
    end else begin
      idle_d = idle_q;
    end

    // Computed from next-state values so the registered blink always equals
    // (clk_mode != 0) && (pre < M_FREQ/2) for the current cycle.
    blink_d = (mode_d != M0) && (pre_d < PRE_HALF);
  end

  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      for (int i = 0; i < 5; i++) begin
        cnt_q[i] <= '0;
      end
      pre_q      <= '0;
      idle_q     <= '0;
      mode_q     <= M0;
      vbutton_q  <= '0;
      mode_chg_q <= 1'b0;
      blink_q    <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      deb_q      <= deb_d;
      for (int i = 0; i < 5; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      pre_q      <= pre_d;
      idle_q     <= idle_d;
      mode_q     <= mode_d;
      vbutton_q  <= vbutton_d;
      mode_chg_q <= mode_chg_d;
      blink_q    <= blink_d;
    end
  end

  assign clk_mode = mode_q;
  assign vButton  = vbutton_q;
  assign mode_chg = mode_chg_q;
  assign blink    = blink_q;

endmodule
`default_nettype wire

// File: tb/tb_clock_mode_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : tb_clock_mode_ctrl                                            |
// | Description: Self-checking bench for clock_mode_ctrl with M_FREQ=10,       |
// |              DEB_CYC=4, TIMEOUT_S=3. Output events are matched against a   |
// |              queue of expected {cycle, mode, vButton, mode_chg} records.   |
// | Revision   : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
module tb_clock_mode_ctrl;

  localparam int M_FREQ    = 10;
  localparam int DEB_CYC   = 4;
  localparam int TIMEOUT_S = 3;
  // Clean rise driven at cycle c appears on the outputs at cycle c + 2 + DEB_CYC + 1.
  localparam int LAT       = 2 + DEB_CYC + 1;
  localparam int NVEC      = 17;

  logic       mclk    = 1'b0;
  logic       rst_n   = 1'b0;
  logic [4:0] pButton = 5'h00;
  logic [1:0] clk_mode;
  logic [3:0] vButton;
  logic       mode_chg;
  logic       blink;

  clock_mode_ctrl #(
    .M_FREQ   (M_FREQ),
    .DEB_CYC  (DEB_CYC),
    .TIMEOUT_S(TIMEOUT_S)
  ) dut (
    .mclk    (mclk),
    .rst     (rst_n),
    .pButton (pButton),
    .clk_mode(clk_mode),
    .vButton (vButton),
    .mode_chg(mode_chg),
    .blink   (blink)
  );

  always #5 mclk = ~mclk;

  // Cycle number since the last reset release; the DUT prescaler equals cyc % M_FREQ.
  int cyc;
  always @(posedge mclk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  typedef struct {
    int         cyc;
    logic [1:0] mode;
    logic [3:0] vb;
    logic       mc;
  } ev_t;

  typedef struct {
    logic [4:0] btn;
    logic [1:0] mode;
    logic [3:0] vb;
    logic       mc;
  } vec_t;

  ev_t  exp_q[$];
  vec_t vecs[NVEC];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int c, input logic [1:0] m, input logic [3:0] vb, input logic mc);
    ev_t e;
    e.cyc = c; e.mode = m; e.vb = vb; e.mc = mc;
    exp_q.push_back(e);
  endtask

  // Called on every falling edge: compare a due expectation, or flag any
  // output event that nothing predicted.
  task automatic scoreboard_step();
    ev_t e;
    if (!rst_n) return;
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      e = exp_q.pop_front();
      check("ev_clk_mode", 8'(clk_mode), 8'(e.mode));
      check("ev_vButton",  8'(vButton),  8'(e.vb));
      check("ev_mode_chg", 8'(mode_chg), 8'(e.mc));
    end else if (vButton != 4'h0 || mode_chg) begin
      checks++;
      failures++;
      $display("FAIL unexpected_event: got mode=%0d vButton=%h mode_chg=%b, required no event (cyc %0d)",
               clk_mode, vButton, mode_chg, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge mclk);
  endtask

  task automatic press(input logic [4:0] bits, input int at, input int hold);
    wait_cyc(at);
    pButton = bits;
    wait_cyc(at + hold);
    pButton = 5'h00;
  endtask

  // Leaves the bench on a falling edge just after release, with cyc == 0.
  task automatic do_reset(input logic [4:0] btn);
    @(negedge mclk);
    rst_n   = 1'b0;
    pButton = btn;
    exp_q.delete();
    repeat (3) @(negedge mclk);
    check("rst_clk_mode", 8'(clk_mode), 8'h0);
    check("rst_vButton",  8'(vButton),  8'h0);
    check("rst_mode_chg", 8'(mode_chg), 8'h0);
    check("rst_blink",    8'(blink),    8'h0);
    rst_n = 1'b1;
  endtask

  task automatic drained(input string name);
    check(name, 8'(exp_q.size()), 8'h0);
  endtask

  initial begin
    #100us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    fork
      forever begin
        @(negedge mclk);
        scoreboard_step();
      end
    join_none

    // {buttons pressed, expected clk_mode, vButton, mode_chg} LAT cycles later
    vecs[0]  = '{5'h01, 2'd0, 4'h0, 1'b0};  // button1 dead in mode 0
    vecs[1]  = '{5'h08, 2'd0, 4'h8, 1'b0};  // setampm live in mode 0
    vecs[2]  = '{5'h10, 2'd1, 4'h0, 1'b1};
    vecs[3]  = '{5'h11, 2'd2, 4'h0, 1'b1};  // button1 + mode together: masked
    vecs[4]  = '{5'h01, 2'd2, 4'h1, 1'b0};
    vecs[5]  = '{5'h02, 2'd2, 4'h2, 1'b0};
    vecs[6]  = '{5'h04, 2'd2, 4'h4, 1'b0};
    vecs[7]  = '{5'h08, 2'd2, 4'h8, 1'b0};
    vecs[8]  = '{5'h10, 2'd3, 4'h0, 1'b1};
    vecs[9]  = '{5'h03, 2'd3, 4'h3, 1'b0};
    vecs[10] = '{5'h10, 2'd0, 4'h0, 1'b1};  // wrap 3 -> 0
    vecs[11] = '{5'h04, 2'd0, 4'h0, 1'b0};
    vecs[12] = '{5'h0C, 2'd0, 4'h8, 1'b0};  // only ampm survives in mode 0
    vecs[13] = '{5'h10, 2'd1, 4'h0, 1'b1};
    vecs[14] = '{5'h18, 2'd2, 4'h0, 1'b1};  // ampm masked by mode press
    vecs[15] = '{5'h10, 2'd3, 4'h0, 1'b1};
    vecs[16] = '{5'h10, 2'd0, 4'h0, 1'b1};

    // Buttons held through reset: all levels accepted together after LAT,
    // so the mode press masks the simultaneous ampm press. Mode 1 entered at
    // cycle 7, idle ticks at 10/20/30, timeout return at 31.
    do_reset(5'h1F);
    push(LAT, 2'd1, 4'h0, 1'b1);
    push(31, 2'd0, 4'h0, 1'b1);
    wait_cyc(3);
    check("blink_mode0", 8'(blink), 8'h0);
    wait_cyc(12);
    check("blink_mode1", 8'(blink), 8'h1);
    pButton = 5'h00;
    wait_cyc(40);
    check("held_timeout_mode", 8'(clk_mode), 8'h0);
    drained("held_drained");

    // Debounce: 3-cycle glitch ignored, 10-cycle press pulses once. That press
    // lands in the timeout cycle, so it is forwarded while mode returns to 0.
    do_reset(5'h00);
    push(1 + LAT, 2'd1, 4'h0, 1'b1);
    press(5'h10, 1, 6);
    press(5'h01, 16, 3);
    push(24 + LAT, 2'd0, 4'h1, 1'b1);
    press(5'h01, 24, 10);
    wait_cyc(45);
    drained("debounce_drained");

    // Mode 2 kept alive by button2 every 20 cycles, then left to time out.
    do_reset(5'h00);
    push(1 + LAT, 2'd1, 4'h0, 1'b1);
    press(5'h10, 1, 6);
    push(15 + LAT, 2'd2, 4'h0, 1'b1);
    press(5'h10, 15, 6);
    for (int k = 0; k < 4; k++) begin
      push(25 + 20 * k + LAT, 2'd2, 4'h2, 1'b0);
      press(5'h02, 25 + 20 * k, 6);
    end
    wait_cyc(100);
    check("keepalive_mode", 8'(clk_mode), 8'h2);
    push(121, 2'd0, 4'h0, 1'b1);
    wait_cyc(130);
    drained("keepalive_drained");

    // Mode press arriving in the timeout cycle wins: 1 -> 2, not 1 -> 0.
    do_reset(5'h00);
    push(1 + LAT, 2'd1, 4'h0, 1'b1);
    press(5'h10, 1, 6);
    push(24 + LAT, 2'd2, 4'h0, 1'b1);
    press(5'h10, 24, 6);
    push(61, 2'd0, 4'h0, 1'b1);
    wait_cyc(70);
    drained("priority_drained");

    // Blink in mode 3 follows the prescaler phase, then async reset mid-high.
    do_reset(5'h00);
    push(1 + LAT, 2'd1, 4'h0, 1'b1);
    press(5'h10, 1, 6);
    push(15 + LAT, 2'd2, 4'h0, 1'b1);
    press(5'h10, 15, 6);
    push(29 + LAT, 2'd3, 4'h0, 1'b1);
    press(5'h10, 29, 6);
    for (int k = 37; k <= 50; k++) begin
      wait_cyc(k);
      check("blink_phase", 8'(blink), ((k % M_FREQ) < (M_FREQ / 2)) ? 8'h1 : 8'h0);
    end
    wait_cyc(51);
    check("blink_pre_rst", 8'(blink), 8'h1);
    check("mode_pre_rst", 8'(clk_mode), 8'h3);
    drained("blink_drained");
    #2 rst_n = 1'b0;
    #1;
    check("async_blink",    8'(blink),    8'h0);
    check("async_clk_mode", 8'(clk_mode), 8'h0);
    check("async_vButton",  8'(vButton),  8'h0);

    // Table-driven sweep, one press every 14 cycles.
    do_reset(5'h00);
    for (int i = 0; i < NVEC; i++) begin
      push(1 + 14 * i + LAT, vecs[i].mode, vecs[i].vb, vecs[i].mc);
      press(vecs[i].btn, 1 + 14 * i, 6);
    end
    wait_cyc(1 + 14 * NVEC + 4);
    drained("table_drained");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
